tff_scan_bist_ctrl: RTL
=======================

Name: tff_scan_bist_ctrl

Overview:
- Built-in self-test controller for a scan chain of CHAIN_LEN scan-muxed T flip-flops.
  - scan_en=1: each stage loads the previous stage's q (shift).
  - scan_en=0: each stage toggles per its T input (capture).
- Generates pseudo-random patterns with an LFSR, shifts them in, and drives a one-cycle capture.
- Compacts shifted-out responses in a MISR and compares the final signature against a golden value.
- Sits between the test-mode top level and the T-FF chain.

Parameters:
- CHAIN_LEN, 8, number of T-FF stages in the chain; legal range 1..16.
- NUM_PATTERNS, 16, number of patterns applied; legal range 1..65535.
- LFSR_SEED, 16'hACE1, LFSR load value on start; must be nonzero.
- MISR_SEED, 16'h0000, MISR load value on start.
- GOLDEN_SIG, 16'h0000, expected final MISR signature.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to begin self-test; sampled only in IDLE.
- chain_clear  out  1  one-cycle pulse that clears every T-FF in the chain.
- scan_en  out  1  chain shift enable.
- scan_in  out  1  serial data into chain stage 0.
- t_vec  out  CHAIN_LEN  T inputs applied to the chain during capture.
- scan_out  in  1  serial data from the last chain stage.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  test complete; held until the next accepted start or clear.
- pass  out  1  valid while done; 1 when signature == GOLDEN_SIG.
- signature  out  16  MISR contents; frozen once done is high.

Behaviour:
- Single clock, clk. Reset clear is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE, counters are 0, LFSR = LFSR_SEED, MISR = MISR_SEED.
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE:
  - start=1 -> INIT.
  - The same edge loads LFSR_SEED and MISR_SEED, zeroes pat_cnt and bit_cnt, and clears done and pass.
- INIT: 1 cycle.
  - chain_clear=1, scan_en=0.
  - Next state SHIFT.
- SHIFT: exactly CHAIN_LEN cycles.
  - scan_en=1, scan_in=lfsr[0].
  - LFSR advances every cycle.
  - When pat_cnt>0, the MISR compacts scan_out every cycle.
  - At pat_cnt=0 the MISR holds, because the chain contains only cleared zeros.
  - bit_cnt==CHAIN_LEN-1 -> CAPTURE, and bit_cnt returns to 0.
- CAPTURE: 1 cycle.
  - scan_en=0, t_vec=lfsr[CHAIN_LEN-1:0]; the LFSR holds.
  - t_vec is 0 in every other state.
  - pat_cnt increments.
  - If the new pat_cnt==NUM_PATTERNS -> UNLOAD, else -> SHIFT.
- UNLOAD: CHAIN_LEN cycles.
  - scan_en=1, scan_in=0.
  - The MISR compacts scan_out every cycle.
  - Then -> COMPARE.
- COMPARE: 1 cycle.
  - The comparison registers pass = (misr==GOLDEN_SIG).
  - Next state DONE.
- DONE:
  - done=1, busy=0.
  - start -> INIT exactly as from IDLE; otherwise stay.
- Busy duration: INIT through COMPARE, which is 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Feedback = l[15]^l[13]^l[12]^l[10], shifted into bit 0 with a left shift.
- MISR:
  - Same polynomial.
  - next = {m[14:0], fb} ^ {15'b0, scan_out}, with fb computed from m.
- start while busy: ignored, with no effect on state, counters or outputs.
- clear mid-operation:
  - Immediate return to IDLE with reset values; the chain is not cleared until the next INIT.
  - A restarted run is bit-identical to an uninterrupted run.
- Counter widths:
  - bit_cnt is $clog2(CHAIN_LEN+1) bits.
  - pat_cnt is 16 bits.
  - No wrap is reachable within the legal parameter ranges.

Decomposition:
- Shared package tff_bist_pkg contains:
  - state enumeration;
  - LFSR_WIDTH=16;
  - polynomial tap constants.
- Sub-module tff_lfsr16, instantiated twice:
  - Ports: clk, clear, load, seed, enable, data_in, q.
  - The generator instance ties data_in to 0.
  - The MISR instance feeds scan_out into data_in.

Test Plan:
1. Reset: assert clear for 2 cycles with start=1.
   -> All outputs 0, signature=16'h0000, no state advance.
2. CHAIN_LEN=4, NUM_PATTERNS=2, start pulse at cycle 0:
   -> chain_clear at cycle 1.
   -> scan_en high in cycles 2-5, 7-10 and 12-15.
   -> capture with scan_en=0 at cycles 6 and 11.
   -> busy high for 16 cycles.
   -> done rises at cycle 17.
3. Default parameters, fault-free T-FF chain model, GOLDEN_SIG set from the bench reference model:
   -> pass=1, and signature equals the model value.
4. Same run with chain stage 3 forced stuck-at-0:
   -> pass=0, and signature != GOLDEN_SIG.
5. Pulse start at cycle 10 of a busy run:
   -> Cycle count and signature are identical to scenario 3.
6. Assert clear mid-SHIFT, then start again:
   -> All outputs 0 immediately.
   -> The rerun signature matches the uninterrupted run.
   -> NUM_PATTERNS=1, CHAIN_LEN=1 gives busy for 1+2+1+1=5 cycles.

Source files
------------

// File: rtl/tff_bist_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tff_bist_pkg                                                            |
// | Shared state encoding and polynomial constants for the scan BIST block. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package tff_bist_pkg;

    localparam int LFSR_WIDTH = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } bist_state_e;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] v,
        input logic                  d
    );
        return {v[LFSR_WIDTH-2:0], ^(v & LFSR_TAPS)} ^ {{(LFSR_WIDTH-1){1'b0}}, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_lfsr16.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tff_lfsr16                                                              |
// | 16-bit Fibonacci LFSR with serial input; doubles as generator and MISR. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tff_lfsr16
    import tff_bist_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  enable,
    input  logic                  data_in,
    output logic [LFSR_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (enable) begin
            q <= lfsr_next(q, data_in);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tff_scan_bist_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tff_scan_bist_ctrl                                                      |
// | LFSR/MISR self-test controller for a scan-muxed T flip-flop chain.      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tff_scan_bist_ctrl
    import tff_bist_pkg::*;
#(
    parameter int          CHAIN_LEN    = 8,
    parameter int          NUM_PATTERNS = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] MISR_SEED    = 16'h0000,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    output logic                 chain_clear,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic [CHAIN_LEN-1:0] t_vec,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          signature
);

    localparam int                    BIT_W      = $clog2(CHAIN_LEN + 1);
    localparam logic [BIT_W-1:0]      C_LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [15:0]           C_NUM_PAT  = 16'(NUM_PATTERNS);

    bist_state_e           r_state;
    bist_state_e           w_state_next;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [15:0]           r_pat_cnt;
    logic                  r_pass;
    logic                  w_start_acc;
    logic                  w_last_bit;
    logic [15:0]           w_pat_inc;
    logic                  w_lfsr_en;
    logic                  w_misr_en;
    logic [LFSR_WIDTH-1:0] w_lfsr_q;
    logic [LFSR_WIDTH-1:0] w_misr_q;
    logic                  w_lfsr_unused;

    assign w_start_acc   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_bit    = (r_bit_cnt == C_LAST_BIT);
    assign w_pat_inc     = r_pat_cnt + 16'd1;
    // Generator bits above the chain width only feed the sequence itself
    assign w_lfsr_unused = ^w_lfsr_q;

    tff_lfsr16 #(
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .clear   (clear),
        .load    (w_start_acc),
        .seed    (LFSR_SEED),
        .enable  (w_lfsr_en),
        .data_in (1'b0),
        .q       (w_lfsr_q)
    );

    tff_lfsr16 #(
        .RESET_VAL (MISR_SEED)
    ) u_misr (
        .clk     (clk),
        .clear   (clear),
        .load    (w_start_acc),
        .seed    (MISR_SEED),
        .enable  (w_misr_en),
        .data_in (scan_out),
        .q       (w_misr_q)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_acc) begin
                r_bit_cnt <= '0;
                r_pat_cnt <= '0;
                r_pass    <= 1'b0;
            end else begin
                case (r_state)
                    ST_SHIFT, ST_UNLOAD: r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
                    ST_CAPTURE:          r_pat_cnt <= w_pat_inc;
                    ST_COMPARE:          r_pass    <= (w_misr_q == GOLDEN_SIG);
                    default:             ;
                endcase
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        chain_clear  = 1'b0;
        scan_en      = 1'b0;
        scan_in      = 1'b0;
        t_vec        = '0;
        busy         = 1'b0;
        done         = 1'b0;
        w_lfsr_en    = 1'b0;
        w_misr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_INIT;
            end
            ST_INIT: begin
                busy         = 1'b1;
                chain_clear  = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                scan_in   = w_lfsr_q[0];
                w_lfsr_en = 1'b1;
                // The first load shifts out only the cleared zeros
                w_misr_en = (r_pat_cnt != 16'd0);
                if (w_last_bit) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                busy         = 1'b1;
                t_vec        = w_lfsr_q[CHAIN_LEN-1:0];
                w_state_next = (w_pat_inc == C_NUM_PAT) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                w_misr_en = 1'b1;
                if (w_last_bit) w_state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                busy         = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) w_state_next = ST_INIT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign pass      = r_pass;
    assign signature = w_misr_q;

endmodule
`default_nettype wire
